// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit hex display driver: one clock, frame-latched inputs, PWM dimming,
// dead-time slot against ghosting and leading-zero suppression.
`timescale 1ns/1ps
module seven_segment_scanner #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int REFRESH_HZ = 500,
  parameter int NUM_DIGITS = 4,
  parameter int DIM_BITS   = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] HEX,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
  input  logic                    LZ_BLANK,
  input  logic [DIM_BITS-1:0]     BRIGHT,
  input  logic                    ENABLE,
  output logic [7:0]              CATHODES,
  output logic [NUM_DIGITS-1:0]   ANODES,
  output logic                    FRAME_TICK
);

  localparam int SLICE = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS * (2 ** DIM_BITS));
  localparam int PW    = (SLICE > 2) ? $clog2(SLICE) : 1;
  localparam int DW    = $clog2(NUM_DIGITS);

  if (SLICE < 2) begin : g_slice_check
    $error("seven_segment_scanner: SLICE must be at least 2");
  end

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'h01;  4'h1: seg7 = 7'h4F;  4'h2: seg7 = 7'h12;  4'h3: seg7 = 7'h06;
      4'h4: seg7 = 7'h4C;  4'h5: seg7 = 7'h24;  4'h6: seg7 = 7'h20;  4'h7: seg7 = 7'h0F;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h0C;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h60;
      4'hC: seg7 = 7'h31;  4'hD: seg7 = 7'h42;  4'hE: seg7 = 7'h30;  default: seg7 = 7'h38;
    endcase
  endfunction

  logic [PW-1:0]           presc_p0;
  logic [DIM_BITS-1:0]     slice_p0;
  logic [DW-1:0]           digit_p0;
  logic                    frame_start;
  logic [4*NUM_DIGITS-1:0] snap_hex;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_en;
  logic                    snap_lz;
  logic [DIM_BITS-1:0]     snap_bright;
  logic                    tick_p1;

  assign frame_start = (presc_p0 == '0) && (slice_p0 == '0) && (digit_p0 == '0);

  // Stage p0: prescaler -> slice -> digit scan counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_p0 <= '0;
      slice_p0 <= '0;
      digit_p0 <= '0;
    end else if (presc_p0 == PW'(SLICE - 1)) begin
      presc_p0 <= '0;
      slice_p0 <= slice_p0 + 1'b1;
      if (slice_p0 == '1)
        digit_p0 <= (digit_p0 == DW'(NUM_DIGITS - 1)) ? '0 : digit_p0 + 1'b1;
    end else begin
      presc_p0 <= presc_p0 + 1'b1;
    end
  end

  // Inputs latch only at frame start so a frame never shows a mix of old and new values
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snap_hex    <= '0;
      snap_dp     <= '0;
      snap_en     <= '0;
      snap_lz     <= 1'b0;
      snap_bright <= '0;
      tick_p1     <= 1'b0;
      FRAME_TICK  <= 1'b0;
    end else begin
      if (frame_start) begin
        snap_hex    <= HEX;
        snap_dp     <= DP;
        snap_en     <= DIGIT_EN;
        snap_lz     <= LZ_BLANK;
        snap_bright <= BRIGHT;
      end
      tick_p1    <= frame_start;
      FRAME_TICK <= tick_p1;
    end
  end

  logic [3:0]              nibble;
  logic [4*NUM_DIGITS-1:0] upper;
  logic                    blank;
  logic                    lit;

  always_comb begin
    nibble = snap_hex[4*digit_p0 +: 4];
    upper  = snap_hex >> (4 * digit_p0);
    blank  = snap_lz && (digit_p0 != '0) && (upper == '0);
    lit    = ENABLE && snap_en[digit_p0] && !blank &&
             (slice_p0 != '0) && (slice_p0 <= snap_bright);
  end

  // Stage p1: registered pin drivers; slice 0 stays dark as anti-ghost dead time
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ANODES   <= '1;
      CATHODES <= 8'hFF;
    end else if (lit) begin
      ANODES   <= ~(NUM_DIGITS'(1) << digit_p0);
      CATHODES <= {~snap_dp[digit_p0], seg7(nibble)};
    end else begin
      ANODES   <= '1;
      CATHODES <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner: per-frame expectations are queued by the
// stimulus and checked by a monitor that integrates lit cycles and cathodes per digit.
`timescale 1ns/1ps
module tb_seven_segment_scanner;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] HEX;
  logic [3:0]  DP;
  logic [3:0]  DIGIT_EN;
  logic        LZ_BLANK;
  logic [3:0]  BRIGHT;
  logic        ENABLE;
  logic [7:0]  CATHODES;
  logic [3:0]  ANODES;
  logic        FRAME_TICK;

  int total = 0;
  int bad = 0;
  int fcount = 0;

  typedef struct packed {
    logic [31:0] frame;
    logic [31:0] cath;  // byte d = cathodes expected on digit d
    logic [31:0] cnt;   // byte d = lit cycles expected on digit d
  } exp_t;

  exp_t sb[$];

  seven_segment_scanner #(
    .CLK_FREQ(128*4*16), .REFRESH_HZ(64), .NUM_DIGITS(4), .DIM_BITS(4)
  ) dut (
    .CLK(CLK), .RST(RST), .HEX(HEX), .DP(DP), .DIGIT_EN(DIGIT_EN),
    .LZ_BLANK(LZ_BLANK), .BRIGHT(BRIGHT), .ENABLE(ENABLE),
    .CATHODES(CATHODES), .ANODES(ANODES), .FRAME_TICK(FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  // Monitor: one window per frame, from a FRAME_TICK sample up to the next one
  initial begin : monitor
    int   obs_cnt [4];
    logic [7:0] obs_cath [4];
    bit   obs_inc [4];
    int   period;
    bit   win;
    exp_t e;
    win = 0;
    period = 0;
    for (int d = 0; d < 4; d++) begin
      obs_cnt[d] = 0; obs_cath[d] = 8'hFF; obs_inc[d] = 0;
    end
    forever begin
      @(negedge CLK);
      if (RST) begin
        win = 0;
      end else begin
        period++;
        if (FRAME_TICK) begin
          if (win) begin
            total++;
            if (period != 128) begin
              bad++;
              $display("FAIL tick_period: got %0d cycles, want 128", period);
            end
            if (sb.size() > 0 && sb[0].frame == 32'(fcount)) begin
              e = sb.pop_front();
              for (int d = 0; d < 4; d++) begin
                total++;
                if (obs_cnt[d] != int'(e.cnt[8*d +: 8])) begin
                  bad++;
                  $display("FAIL lit_count frame %0d digit %0d: got %0d, want %0d",
                           fcount, d, obs_cnt[d], e.cnt[8*d +: 8]);
                end
                if (e.cnt[8*d +: 8] != 8'd0) begin
                  total++;
                  if (obs_inc[d] || obs_cath[d] != e.cath[8*d +: 8]) begin
                    bad++;
                    $display("FAIL cathodes frame %0d digit %0d: got %02h (unstable=%0d), want %02h",
                             fcount, d, obs_cath[d], obs_inc[d], e.cath[8*d +: 8]);
                  end
                end
              end
            end
          end
          fcount++;
          win = 1;
          period = 0;
          for (int d = 0; d < 4; d++) begin
            obs_cnt[d] = 0; obs_cath[d] = 8'hFF; obs_inc[d] = 0;
          end
        end
        if (win && ANODES != 4'hF) begin
          total++;
          if ($countones(~ANODES) != 1) begin
            bad++;
            $display("FAIL one_anode: got ANODES=%04b, want exactly one low", ANODES);
          end else begin
            for (int d = 0; d < 4; d++) begin
              if (!ANODES[d]) begin
                if (obs_cnt[d] != 0 && CATHODES != obs_cath[d]) obs_inc[d] = 1;
                obs_cath[d] = CATHODES;
                obs_cnt[d]++;
              end
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic wait_tick(output int f);
    int n;
    n = 0;
    @(negedge CLK);
    while (!FRAME_TICK && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (!FRAME_TICK) begin
      total++;
      bad++;
      $display("FAIL wait_tick: no FRAME_TICK within 400 cycles, got 0 want 1");
    end
    #1 f = fcount;
  endtask

  // Change the inputs mid-frame; the current frame keeps its old snapshot
  task automatic apply(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] en,
                       input logic lz, input logic [3:0] br,
                       input logic [31:0] cath, input logic [31:0] cnt);
    int f;
    wait_tick(f);
    repeat (40) @(negedge CLK);
    HEX = h; DP = dp; DIGIT_EN = en; LZ_BLANK = lz; BRIGHT = br;
    sb.push_back('{32'(f + 1), cath, cnt});
  endtask

  initial begin : stim
    int f;
    int n;
    RST = 1'b1;
    HEX = 16'h12AF; DP = 4'b0000; DIGIT_EN = 4'b1111; LZ_BLANK = 1'b0;
    BRIGHT = 4'd15; ENABLE = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_anodes", 32'(ANODES), 32'hF);
    check("reset_cathodes", 32'(CATHODES), 32'hFF);
    check("reset_tick", 32'(FRAME_TICK), 32'h0);
    sb.push_back('{32'(fcount + 1), 32'hCF9288B8, 32'h1E1E1E1E});
    RST = 1'b0;
    @(posedge CLK); #1 check("tick_after_edge1", 32'(FRAME_TICK), 32'h0);
    @(posedge CLK); #1 check("tick_after_edge2", 32'(FRAME_TICK), 32'h1);

    apply(16'h3456, 4'b0000, 4'b1111, 1'b0, 4'd15, 32'h86CCA4A0, 32'h1E1E1E1E);
    apply(16'h0070, 4'b0000, 4'b1111, 1'b1, 4'd15, 32'hFFFF8F81, 32'h00001E1E);
    apply(16'h0000, 4'b0000, 4'b1111, 1'b1, 4'd15, 32'hFFFFFF81, 32'h0000001E);
    apply(16'h0005, 4'b0010, 4'b1111, 1'b1, 4'd15, 32'hFFFFFFA4, 32'h0000001E);
    apply(16'h0300, 4'b0000, 4'b1011, 1'b1, 4'd15, 32'hFFFF8181, 32'h00001E1E);
    apply(16'h12AF, 4'b0000, 4'b1111, 1'b0, 4'd3,  32'hCF9288B8, 32'h06060606);
    apply(16'h12AF, 4'b0000, 4'b1111, 1'b0, 4'd0,  32'hCF9288B8, 32'h00000000);
    apply(16'h12AF, 4'b0100, 4'b1011, 1'b0, 4'd15, 32'hCF9288B8, 32'h1E001E1E);
    apply(16'h12AF, 4'b1001, 4'b1111, 1'b0, 4'd15, 32'h4F928838, 32'h1E1E1E1E);

    // ENABLE acts one cycle later and is not held by the snapshot
    wait_tick(f);
    wait_tick(f);
    n = 0;
    while (ANODES == 4'hF && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("lit_before_disable", 32'(ANODES != 4'hF), 32'h1);
    ENABLE = 1'b0;
    sb.push_back('{32'(f + 1), 32'hFFFFFFFF, 32'h00000000});
    @(posedge CLK); #1;
    check("disable_anodes", 32'(ANODES), 32'hF);
    check("disable_cathodes", 32'(CATHODES), 32'hFF);
    wait_tick(f);
    wait_tick(f);
    ENABLE = 1'b1;

    // Asynchronous reset in the middle of a dwell
    wait_tick(f);
    repeat (50) @(negedge CLK);
    check("lit_before_reset", 32'(ANODES != 4'hF), 32'h1);
    #3 RST = 1'b1;
    #1;
    check("async_reset_anodes", 32'(ANODES), 32'hF);
    check("async_reset_cathodes", 32'(CATHODES), 32'hFF);
    repeat (3) @(negedge CLK);
    HEX = 16'h12AF; DP = 4'b0000; DIGIT_EN = 4'b1111; LZ_BLANK = 1'b0; BRIGHT = 4'd15;
    sb.push_back('{32'(fcount + 1), 32'hCF9288B8, 32'h1E1E1E1E});
    RST = 1'b0;
    @(posedge CLK); #1 check("rerun_tick_edge1", 32'(FRAME_TICK), 32'h0);
    @(posedge CLK); #1 check("rerun_tick_edge2", 32'(FRAME_TICK), 32'h1);
    wait_tick(f);
    wait_tick(f);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
